// File: rtl/line_follower_pwm_ctrl.sv
// line_follower_pwm_ctrl
//   Line-follower motor controller. Three raw line sensors are debounced per
//   bit and mapped to a steering target. A six-state steering FSM turns that
//   target into a per-motor direction command (fwd/rev/off) and a duty
//   cycle. Each motor output gets a PWM gate and a reversal dead time before
//   it is registered. There are no handshakes: all inputs are sampled every
//   clock and all outputs are valid every clock.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset
//   enable     run request; low forces IDLE
//   sensors    {f,l,r} raw line sensors, 1 = line under sensor
//   duty_fwd   PWM duty used in FWD
//   duty_turn  PWM duty used in LEFT/RIGHT/SEARCH
//   motor_a    {fwd,rev} left motor pins, registered
//   motor_b    {fwd,rev} right motor pins, registered
//   state_o    current FSM state code
//   lost       set on entry to HALT, cleared in IDLE, registered
module line_follower_pwm_ctrl #(
    parameter int DUTY_W       = 8,
    parameter int PERIOD       = 250,
    parameter int DEBOUNCE     = 4,
    parameter int LOST_TIMEOUT = 1000,
    parameter int DEADTIME     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [2:0]        sensors,
    input  logic [DUTY_W-1:0] duty_fwd,
    input  logic [DUTY_W-1:0] duty_turn,
    output logic [1:0]        motor_a,
    output logic [1:0]        motor_b,
    output logic [2:0]        state_o,
    output logic              lost
);

    // State codes
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FWD    = 3'd1;
    localparam logic [2:0] S_RIGHT  = 3'd2;
    localparam logic [2:0] S_LEFT   = 3'd3;
    localparam logic [2:0] S_SEARCH = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    // Direction commands, laid out as the {fwd,rev} pin pair
    localparam logic [1:0] DIR_OFF = 2'b00;
    localparam logic [1:0] DIR_FWD = 2'b10;
    localparam logic [1:0] DIR_REV = 2'b01;

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam int SR_W = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT + 1) : 1;
    localparam int DT_W = (DEADTIME > 1) ? $clog2(DEADTIME + 1) : 1;

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [SR_W-1:0]   SR_LAST  = SR_W'(LOST_TIMEOUT - 1);
    localparam logic [DT_W-1:0]   DT_FULL  = DT_W'(DEADTIME);
    localparam logic [DUTY_W-1:0] PWM_LAST = DUTY_W'(PERIOD - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]            state_q, state_d;
    logic [2:0]            deb_q, deb_d;
    logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [DUTY_W-1:0]     pwm_cnt_q, pwm_cnt_d;
    logic [SR_W-1:0]       search_q, search_d;
    logic                  last_left_q, last_left_d;   // 0 = RIGHT, 1 = LEFT
    logic                  lost_q, lost_d;
    // Index 0 = motor A (left), index 1 = motor B (right)
    logic [1:0][1:0]       prev_cmd_q, prev_cmd_d;     // command seen last cycle
    logic [1:0][1:0]       last_drv_q, last_drv_d;     // direction last actually driven
    logic [1:0][DT_W-1:0]  dt_cnt_q, dt_cnt_d;         // remaining dead cycles after this one
    logic [1:0][1:0]       pin_q, pin_d;

    // Combinational helpers
    logic [2:0]            target;
    logic [1:0][1:0]       cmd;
    logic [DUTY_W-1:0]     duty_sel;
    logic                  pwm_on;
    logic [1:0]            rev_start;
    logic [1:0][DT_W-1:0]  dt_rem;
    logic [1:0][1:0]       eff_dir;

    // ------------------------------------------------------------------
    // Sensor debounce: a bit flips only after DEBOUNCE consecutive samples
    // that disagree with the current debounced value.
    // ------------------------------------------------------------------
    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (sensors[i] == deb_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                deb_d[i]    = sensors[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    // Steering target from debounced {f,l,r}
    always_comb begin
        target = S_SEARCH;
        case (deb_q)
            3'b000:                    target = S_SEARCH;
            3'b100, 3'b011, 3'b111:    target = S_FWD;
            3'b010, 3'b110:            target = S_LEFT;
            3'b001, 3'b101:            target = S_RIGHT;
            default:                   target = S_SEARCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Steering FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_FWD, S_LEFT, S_RIGHT: state_d = target;
                S_SEARCH: begin
                    if (target != S_SEARCH) begin
                        state_d = target;
                    end else if (search_q == SR_LAST) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_SEARCH;
                    end
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IDLE;    // codes 6/7 recover
            endcase
        end
    end

    always_comb begin
        cmd      = '0;
        duty_sel = '0;
        case (state_q)
            S_FWD: begin
                cmd[0]   = DIR_FWD;
                cmd[1]   = DIR_FWD;
                duty_sel = duty_fwd;
            end
            S_LEFT: begin
                cmd[0]   = DIR_REV;
                cmd[1]   = DIR_FWD;
                duty_sel = duty_turn;
            end
            S_RIGHT: begin
                cmd[0]   = DIR_FWD;
                cmd[1]   = DIR_REV;
                duty_sel = duty_turn;
            end
            S_SEARCH: begin
                cmd[0]   = last_left_q ? DIR_REV : DIR_FWD;
                cmd[1]   = last_left_q ? DIR_FWD : DIR_REV;
                duty_sel = duty_turn;
            end
            default: begin
                cmd      = '0;
                duty_sel = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Search timer, last turn, lost flag, PWM counter
    // ------------------------------------------------------------------
    always_comb begin
        search_d    = (state_q == S_SEARCH) ? search_q + SR_W'(1) : '0;
        last_left_d = last_left_q;
        if (state_d == S_LEFT) begin
            last_left_d = 1'b1;
        end else if (state_d == S_RIGHT) begin
            last_left_d = 1'b0;
        end
        lost_d = lost_q;
        if (state_d == S_HALT) begin
            lost_d = 1'b1;
        end else if (state_d == S_IDLE) begin
            lost_d = 1'b0;
        end
        pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + DUTY_W'(1);
    end

    // duty >= PERIOD keeps this high because the counter never exceeds PERIOD-1
    assign pwm_on = (pwm_cnt_q < duty_sel);

    // ------------------------------------------------------------------
    // Dead time. Outside a dead window a reversal is judged against last
    // cycle's command; inside one it is judged against the direction that
    // was driven before the window opened, so flipping back to the original
    // direction does not extend the window.
    // ------------------------------------------------------------------
    always_comb begin
        rev_start  = '0;
        dt_rem     = '0;
        eff_dir    = '0;
        dt_cnt_d   = '0;
        last_drv_d = last_drv_q;
        prev_cmd_d = cmd;
        pin_d      = '0;
        for (int m = 0; m < 2; m++) begin
            if (dt_cnt_q[m] != '0) begin
                rev_start[m] = (cmd[m] != prev_cmd_q[m]) && (cmd[m] != DIR_OFF) &&
                               (last_drv_q[m] != DIR_OFF) && (cmd[m] != last_drv_q[m]);
            end else begin
                rev_start[m] = (cmd[m] != prev_cmd_q[m]) && (cmd[m] != DIR_OFF) &&
                               (prev_cmd_q[m] != DIR_OFF);
            end
            dt_rem[m] = rev_start[m] ? DT_FULL : dt_cnt_q[m];
            if (dt_rem[m] != '0) begin
                eff_dir[m]  = DIR_OFF;
                dt_cnt_d[m] = dt_rem[m] - DT_W'(1);
            end else begin
                eff_dir[m]    = cmd[m];
                dt_cnt_d[m]   = '0;
                last_drv_d[m] = cmd[m];
            end
            pin_d[m] = eff_dir[m] & {2{pwm_on}};
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q       <= '0;
            db_cnt_q    <= '0;
            pwm_cnt_q   <= '0;
            search_q    <= '0;
            last_left_q <= 1'b0;
            lost_q      <= 1'b0;
            prev_cmd_q  <= '0;
            last_drv_q  <= '0;
            dt_cnt_q    <= '0;
            pin_q       <= '0;
        end else begin
            deb_q       <= deb_d;
            db_cnt_q    <= db_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            search_q    <= search_d;
            last_left_q <= last_left_d;
            lost_q      <= lost_d;
            prev_cmd_q  <= prev_cmd_d;
            last_drv_q  <= last_drv_d;
            dt_cnt_q    <= dt_cnt_d;
            pin_q       <= pin_d;
        end
    end

    assign motor_a = pin_q[0];
    assign motor_b = pin_q[1];
    assign state_o = state_q;
    assign lost    = lost_q;

endmodule

// File: tb/tb_line_follower_pwm_ctrl.sv
// Bench for line_follower_pwm_ctrl: directed scenarios followed by random
// sensor/enable/duty/reset traffic, compared every cycle against a reference
// model built from the behavioural rules (run lengths, absolute dead-time
// deadlines, a target lookup table).
module tb_line_follower_pwm_ctrl;
  localparam int DUTY_W       = 4;
  localparam int PERIOD       = 10;
  localparam int DEBOUNCE     = 2;
  localparam int LOST_TIMEOUT = 20;
  localparam int DEADTIME     = 3;

  // ---------------- clock / reset / DUT ----------------
  logic              clk;
  logic              reset;
  logic              enable;
  logic [2:0]        sensors;
  logic [DUTY_W-1:0] duty_fwd;
  logic [DUTY_W-1:0] duty_turn;
  logic [1:0]        motor_a;
  logic [1:0]        motor_b;
  logic [2:0]        state_o;
  logic              lost;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  line_follower_pwm_ctrl #(
    .DUTY_W(DUTY_W), .PERIOD(PERIOD), .DEBOUNCE(DEBOUNCE),
    .LOST_TIMEOUT(LOST_TIMEOUT), .DEADTIME(DEADTIME)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sensors(sensors),
    .duty_fwd(duty_fwd), .duty_turn(duty_turn),
    .motor_a(motor_a), .motor_b(motor_b), .state_o(state_o), .lost(lost)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // state codes: 0 IDLE, 1 FWD, 2 RIGHT, 3 LEFT, 4 SEARCH, 5 HALT
  // directions: 0 off, 1 forward, 2 reverse
  int tgt_tab[8] = '{4, 2, 3, 1, 1, 2, 3, 1};   // indexed by {f,l,r}
  int m_deb[3], m_run[3];
  int m_state, m_search, m_left, m_lost, m_phase, m_cyc;
  int m_prev[2], m_drv[2], m_dead_until[2], m_pin[2];

  function automatic int dir_bits(input int d);
    return (d == 1) ? 2 : (d == 2) ? 1 : 0;
  endfunction

  task automatic model_edge();
    int duty, pwm, nxt, tgt;
    int want[2];
    bit changed, in_dead, rev;
    if (reset) begin
      m_state = 0; m_search = 0; m_left = 0; m_lost = 0; m_phase = 0;
      for (int i = 0; i < 3; i++) begin m_deb[i] = 0; m_run[i] = 0; end
      for (int m = 0; m < 2; m++) begin
        m_prev[m] = 0; m_drv[m] = 0; m_dead_until[m] = 0; m_pin[m] = 0;
      end
    end else begin
      duty = (m_state == 1) ? int'(duty_fwd) :
             (m_state >= 2 && m_state <= 4) ? int'(duty_turn) : 0;
      pwm  = (m_phase < duty) ? 1 : 0;
      want = '{0, 0};
      case (m_state)
        1: want = '{1, 1};
        2: want = '{1, 2};
        3: want = '{2, 1};
        4: want = (m_left != 0) ? '{2, 1} : '{1, 2};
        default: want = '{0, 0};
      endcase
      for (int m = 0; m < 2; m++) begin
        changed = (want[m] != m_prev[m]);
        in_dead = (m_cyc < m_dead_until[m]);
        if (in_dead) rev = changed && want[m] != 0 && m_drv[m] != 0 && want[m] != m_drv[m];
        else         rev = changed && want[m] != 0 && m_prev[m] != 0;
        if (rev) m_dead_until[m] = m_cyc + DEADTIME;
        if (m_cyc < m_dead_until[m]) m_pin[m] = 0;
        else begin
          m_drv[m] = want[m];
          m_pin[m] = (pwm != 0) ? dir_bits(want[m]) : 0;
        end
        m_prev[m] = want[m];
      end
      m_phase = (m_phase + 1) % PERIOD;

      tgt = tgt_tab[m_deb[2] * 4 + m_deb[1] * 2 + m_deb[0]];
      if (!enable) nxt = 0;
      else begin
        case (m_state)
          0, 1, 2, 3: nxt = tgt;
          4: nxt = (tgt != 4) ? tgt : ((m_search == LOST_TIMEOUT - 1) ? 5 : 4);
          5: nxt = 5;
          default: nxt = 0;
        endcase
      end
      m_search = (m_state == 4) ? m_search + 1 : 0;
      if (nxt == 3) m_left = 1;
      if (nxt == 2) m_left = 0;
      if (nxt == 5) m_lost = 1;
      else if (nxt == 0) m_lost = 0;
      m_state = nxt;

      for (int i = 0; i < 3; i++) begin
        if (int'(sensors[i]) == m_deb[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DEBOUNCE) begin m_deb[i] = int'(sensors[i]); m_run[i] = 0; end
        end
      end
    end
    m_cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("state_o", state_o, m_state);
    check_eq("motor_a", motor_a, m_pin[0]);
    check_eq("motor_b", motor_b, m_pin[1]);
    check_eq("lost", lost, m_lost);
    check_eq("excl_a", motor_a[1] & motor_a[0], 0);
    check_eq("excl_b", motor_b[1] & motor_b[0], 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // counts cycles over n ticks where the chosen motor equals val
  task automatic count_pins(input int n, input int sel, input logic [1:0] val, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (((sel == 0) ? motor_a : motor_b) == val) hits++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hits;
    int hold;
    m_cyc = 0;
    reset = 1'b1; enable = 1'b0; sensors = 3'b100; duty_fwd = 4'd6; duty_turn = 4'd3;
    run(2);
    check_eq("rst_state", state_o, 0);
    check_eq("rst_motor_a", motor_a, 0);
    check_eq("rst_lost", lost, 0);
    reset = 1'b0;

    // 1: disabled stays idle, then forward at duty 6/10
    run(12);
    check_eq("t1_idle", state_o, 0);
    enable = 1'b1;
    run(12);
    check_eq("t1_fwd", state_o, 1);
    count_pins(10, 0, 2'b10, hits);
    check_eq("t1_a_duty", hits, 6);
    count_pins(10, 1, 2'b10, hits);
    check_eq("t1_b_duty", hits, 6);

    // 2: one-cycle glitch ignored, held change turns left with dead time
    sensors = 3'b010; run(1);
    sensors = 3'b100; run(6);
    check_eq("t2_glitch", state_o, 1);
    sensors = 3'b010; run(20);
    check_eq("t2_left", state_o, 3);
    count_pins(10, 0, 2'b01, hits);
    check_eq("t2_a_rev_duty", hits, 3);
    count_pins(10, 1, 2'b10, hits);
    check_eq("t2_b_fwd_duty", hits, 3);

    // 3: right, lose the line, time out into HALT
    sensors = 3'b001; run(10);
    check_eq("t3_right", state_o, 2);
    sensors = 3'b000; run(6);
    check_eq("t3_search", state_o, 4);
    run(25);
    check_eq("t3_halt", state_o, 5);
    check_eq("t3_lost", lost, 1);
    sensors = 3'b100; run(6);
    check_eq("t3_halt_hold", state_o, 5);
    enable = 1'b0; run(2);
    check_eq("t3_idle", state_o, 0);
    check_eq("t3_lost_clr", lost, 0);
    enable = 1'b1;

    // 4: line found again partway through search
    sensors = 3'b001; run(10);
    sensors = 3'b000; run(12);
    check_eq("t4_searching", state_o, 4);
    sensors = 3'b001; run(6);
    check_eq("t4_recover", state_o, 2);
    check_eq("t4_lost", lost, 0);
    run(25);
    check_eq("t4_no_halt", state_o, 2);

    // 5: duty extremes in FWD
    sensors = 3'b100; duty_fwd = 4'd0; run(12);
    count_pins(10, 0, 2'b00, hits);
    check_eq("t5_duty0", hits, 10);
    duty_fwd = 4'd15; run(2);
    count_pins(10, 0, 2'b10, hits);
    check_eq("t5_duty_full_a", hits, 10);
    count_pins(10, 1, 2'b10, hits);
    check_eq("t5_duty_full_b", hits, 10);
    duty_fwd = 4'd6;

    // 6: reset in the middle of a dead-time window
    run(5);
    sensors = 3'b010; run(4);
    reset = 1'b1; run(1);
    check_eq("t6_state", state_o, 0);
    check_eq("t6_motor_a", motor_a, 0);
    check_eq("t6_motor_b", motor_b, 0);
    reset = 1'b0; run(15);

    // random traffic
    for (int seg = 0; seg < 450; seg++) begin
      sensors = 3'($urandom_range(0, 7));
      hold = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 6);
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) duty_fwd  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) duty_turn = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 99) == 0);
      run(1);
      reset = 1'b0;
      run(hold);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
